// File: rtl/addsub_serial.sv
// Digit-serial unsigned adder/subtractor: DIGIT bits per cycle, LSB digit first,
// with a registered WIDTH+1 bit result, done pulse and zero flag.
module addsub_serial #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             MODE,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH:0]   D,
    output logic             ZERO
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || WIDTH > 64 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("addsub_serial: WIDTH must be 2..64 and an integer multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               mode_q, mode_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [WIDTH:0]     d_q, d_d;
    logic               zero_q, zero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [DIGIT-1:0]   a_dig;
    logic [DIGIT-1:0]   b_dig;
    logic [DIGIT:0]     dsum;
    logic [WIDTH-1:0]   sum_shift;
    logic [WIDTH:0]     result;

    // One digit of A + (B or ~B) + carry; the new digit enters the sum register at the top.
    always_comb begin
        a_dig     = a_q[DIGIT-1:0];
        b_dig     = b_q[DIGIT-1:0] ^ {DIGIT{mode_q}};
        dsum      = (DIGIT+1)'(a_dig) + (DIGIT+1)'(b_dig) + (DIGIT+1)'(carry_q);
        sum_shift = (sum_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
        result    = {dsum[DIGIT] ^ mode_q, sum_shift};
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        mode_d  = mode_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        d_d     = d_q;
        zero_d  = zero_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = RUN;
                    a_d     = A;
                    b_d     = B;
                    mode_d  = MODE;
                    carry_d = MODE;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dsum[DIGIT];
                sum_d   = sum_shift;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = FIN;
                    d_d     = result;
                    zero_d  = (result == '0);
                end
            end
            FIN: begin
                if (START) begin
                    state_d = RUN;
                    a_d     = A;
                    b_d     = B;
                    mode_d  = MODE;
                    carry_d = MODE;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status flags are registered copies of the state being entered.
        busy_d = (state_d == RUN);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            mode_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            d_q     <= '0;
            zero_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            d_q     <= d_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign D    = d_q;
    assign ZERO = zero_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial: four configurations checked against
// a plain-arithmetic (A +/- B) mod 2^(WIDTH+1) model.
module tb_addsub_serial;

    localparam int unsigned NI = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start [NI];
    logic        mode  [NI];
    logic [15:0] a     [NI];
    logic [15:0] b     [NI];
    logic        busy  [NI];
    logic        done  [NI];
    logic        zero  [NI];
    logic [4:0]  d0;
    logic [8:0]  d1;
    logic [16:0] d2;
    logic [4:0]  d3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(4), .DIGIT(1)) u_dut0 (
        .CLK(clk), .RST_N(rst_n), .START(start[0]), .MODE(mode[0]),
        .A(a[0][3:0]), .B(b[0][3:0]), .BUSY(busy[0]), .DONE(done[0]),
        .D(d0), .ZERO(zero[0]));

    addsub_serial #(.WIDTH(8), .DIGIT(2)) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .START(start[1]), .MODE(mode[1]),
        .A(a[1][7:0]), .B(b[1][7:0]), .BUSY(busy[1]), .DONE(done[1]),
        .D(d1), .ZERO(zero[1]));

    addsub_serial #(.WIDTH(16), .DIGIT(4)) u_dut2 (
        .CLK(clk), .RST_N(rst_n), .START(start[2]), .MODE(mode[2]),
        .A(a[2]), .B(b[2]), .BUSY(busy[2]), .DONE(done[2]),
        .D(d2), .ZERO(zero[2]));

    addsub_serial #(.WIDTH(4), .DIGIT(4)) u_dut3 (
        .CLK(clk), .RST_N(rst_n), .START(start[3]), .MODE(mode[3]),
        .A(a[3][3:0]), .B(b[3][3:0]), .BUSY(busy[3]), .DONE(done[3]),
        .D(d3), .ZERO(zero[3]));

    function automatic int unsigned w_of(int k);
        case (k)
            0: return 4;
            1: return 8;
            2: return 16;
            default: return 4;
        endcase
    endfunction

    function automatic int unsigned dg_of(int k);
        case (k)
            0: return 1;
            1: return 2;
            2: return 4;
            default: return 4;
        endcase
    endfunction

    function automatic longint unsigned d_of(int k);
        case (k)
            0: return 64'(d0);
            1: return 64'(d1);
            2: return 64'(d2);
            default: return 64'(d3);
        endcase
    endfunction

    function automatic longint unsigned model(int k, bit m, longint unsigned x, longint unsigned y);
        longint unsigned r;
        r = m ? (x - y) : (x + y);
        return r & ((64'd1 << (w_of(k) + 1)) - 64'd1);
    endfunction

    task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One operation on instance k; optional START glitch mid-RUN with other operands.
    task automatic run_op(input int k, input bit m, input longint unsigned x,
                          input longint unsigned y, input bit glitch);
        int n;
        int lat;
        int busy_cnt;
        bit seen;
        longint unsigned e;
        n = int'(w_of(k) / dg_of(k));
        lat = 0;
        busy_cnt = 0;
        seen = 1'b0;
        e = model(k, m, x, y);
        @(negedge clk);
        start[k] = 1'b1;
        mode[k]  = m;
        a[k]     = 16'(x);
        b[k]     = 16'(y);
        @(posedge clk);
        #1;
        start[k] = 1'b0;
        mode[k]  = ~m;
        a[k]     = 16'($urandom);
        b[k]     = 16'($urandom);
        for (int c = 1; c <= n + 8 && !seen; c++) begin
            if (busy[k]) busy_cnt++;
            if (glitch && c == 2) begin
                start[k] = 1'b1;
                mode[k]  = $urandom_range(0, 1) != 0;
                a[k]     = 16'($urandom);
                b[k]     = 16'($urandom);
            end
            if (glitch && c == 3) start[k] = 1'b0;
            @(posedge clk);
            #1;
            if (done[k]) begin
                seen = 1'b1;
                lat  = c + 1;
            end
        end
        chk($sformatf("done_seen[%0d]", k), 64'(seen), 64'd1);
        chk($sformatf("latency[%0d]", k), 64'(lat), 64'(n + 1));
        chk($sformatf("busy_cycles[%0d]", k), 64'(busy_cnt), 64'(n));
        chk($sformatf("busy_in_fin[%0d]", k), 64'(busy[k]), 64'd0);
        chk($sformatf("d[%0d] %0h%s%0h", k, x, m ? "-" : "+", y), d_of(k), e);
        chk($sformatf("zero[%0d]", k), 64'(zero[k]), 64'(e == 0));
        @(posedge clk);
        #1;
        chk($sformatf("done_pulse[%0d]", k), 64'(done[k]), 64'd0);
        chk($sformatf("d_hold[%0d]", k), d_of(k), e);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        longint unsigned q[$];
        longint unsigned mask;
        longint unsigned x;
        longint unsigned y;
        bit m;
        bit seen;
        int lat;

        for (int k = 0; k < int'(NI); k++) begin
            start[k] = 1'b0;
            mode[k]  = 1'b0;
            a[k]     = '0;
            b[k]     = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < int'(NI); k++) begin
            chk($sformatf("rst_busy[%0d]", k), 64'(busy[k]), 64'd0);
            chk($sformatf("rst_done[%0d]", k), 64'(done[k]), 64'd0);
            chk($sformatf("rst_d[%0d]", k), d_of(k), 64'd0);
            chk($sformatf("rst_zero[%0d]", k), 64'(zero[k]), 64'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        run_op(0, 1'b1, 64'h3, 64'h5, 1'b0);
        run_op(0, 1'b1, 64'hF, 64'hF, 1'b0);
        run_op(0, 1'b0, 64'hF, 64'h7, 1'b0);
        run_op(0, 1'b1, 64'h7, 64'h3, 1'b0);
        run_op(1, 1'b1, 64'h00, 64'h01, 1'b0);
        run_op(1, 1'b0, 64'hFF, 64'hFF, 1'b0);
        run_op(2, 1'b1, 64'h0000, 64'hFFFF, 1'b0);
        run_op(3, 1'b0, 64'hF, 64'h1, 1'b0);
        run_op(0, 1'b0, 64'h9, 64'h5, 1'b1);

        // Back-to-back with START held high on instance 0
        q.delete();
        @(negedge clk);
        x = 64'($urandom_range(0, 15));
        y = 64'($urandom_range(0, 15));
        m = $urandom_range(0, 1) != 0;
        start[0] = 1'b1; mode[0] = m; a[0] = 16'(x); b[0] = 16'(y);
        q.push_back(model(0, m, x, y));
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            seen = 1'b0;
            lat = 0;
            for (int c = 1; c <= 20 && !seen; c++) begin
                @(posedge clk);
                #1;
                if (done[0]) begin
                    seen = 1'b1;
                    lat  = c;
                end
            end
            chk("b2b_done_seen", 64'(seen), 64'd1);
            chk("b2b_interval", 64'(lat), (i == 0) ? 64'd4 : 64'd5);
            chk("b2b_d", d_of(0), q.pop_front());
            if (i < 5) begin
                x = 64'($urandom_range(0, 15));
                y = 64'($urandom_range(0, 15));
                m = $urandom_range(0, 1) != 0;
                mode[0] = m; a[0] = 16'(x); b[0] = 16'(y);
                q.push_back(model(0, m, x, y));
            end else begin
                start[0] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("b2b_idle_busy", 64'(busy[0]), 64'd0);

        // Reset during the second RUN cycle aborts the operation
        @(negedge clk);
        start[0] = 1'b1; mode[0] = 1'b0; a[0] = 16'h9; b[0] = 16'h3;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy[0]), 64'd0);
        chk("arst_done", 64'(done[0]), 64'd0);
        chk("arst_d", d_of(0), 64'd0);
        chk("arst_zero", 64'(zero[0]), 64'd1);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done[0]) seen = 1'b1;
        end
        chk("arst_no_done", 64'(seen), 64'd0);
        rst_n = 1'b1;
        run_op(0, 1'b1, 64'h2, 64'hB, 1'b0);

        // Randomised operations on every configuration
        for (int k = 0; k < int'(NI); k++) begin
            mask = (64'd1 << w_of(k)) - 64'd1;
            for (int i = 0; i < 25; i++) begin
                x = 64'($urandom) & mask;
                y = 64'($urandom) & mask;
                if (i == 0) y = x;
                if (i == 1) begin x = 0; y = mask; end
                m = $urandom_range(0, 1) != 0;
                run_op(k, m, x, y, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/addsub_serial.md
ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits; legal range 2..64.
REQ-002 SHALL have parameter DIGIT, default 1: bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT (elaboration error otherwise).
REQ-003 SHALL have port CLK, input, 1: single clock; all state changes on rising edge.
REQ-004 SHALL have port RST_N, input, 1: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port START, input, 1: request to begin an operation.
REQ-006 SHALL have port MODE, input, 1: 0 = add, 1 = subtract; sampled with START.
REQ-007 SHALL have port A, input, WIDTH: first operand, unsigned; sampled with START.
REQ-008 SHALL have port B, input, WIDTH: second operand, unsigned; sampled with START.
REQ-009 SHALL have port BUSY, output, 1: an operation is in progress.
REQ-010 SHALL have port DONE, output, 1: one-cycle pulse; D is valid for a new result.
REQ-011 SHALL have port D, output, WIDTH+1: result; D[WIDTH] is carry (add) or borrow (sub).
REQ-012 SHALL have port ZERO, output, 1: D equals zero for the held result.

Function
REQ-013 SHALL compute D = (A + B) mod 2^(WIDTH+1) for MODE=0 and D = (A - B) mod 2^(WIDTH+1) for MODE=1, operands zero-extended to WIDTH+1 bits.
REQ-014 SHALL implement subtraction as A + ~B + 1, with the initial carry-in = MODE; D[WIDTH] = carry-out XOR MODE.
REQ-015 SHALL process DIGIT bits per cycle, LSB digit first, carrying between digits in a 1-bit register; N = WIDTH/DIGIT digit cycles per operation.
REQ-016 SHALL use FSM states IDLE, RUN and FIN.
REQ-017 IDLE -> RUN on an edge with START=1; A, B and MODE are captured on that edge, and the digit counter is cleared.
REQ-018 RUN SHALL last exactly N cycles, one digit per edge, with the counter incrementing 0..N-1; RUN -> FIN on the edge that processes digit N-1.
REQ-019 In FIN, DONE=1 for exactly one cycle with D and ZERO updated; FIN -> IDLE, or FIN -> RUN if START=1 in that cycle (back-to-back, new operands captured).
REQ-020 Latency: DONE SHALL be high in the cycle following the (N+1)th rising edge counted from the START-capture edge inclusive (N+1 cycles start to DONE).
REQ-021 BUSY SHALL be 1 in RUN and 0 in IDLE and FIN.
REQ-022 START while in RUN SHALL be ignored; no state, operand or counter change.
REQ-023 Changes on A, B or MODE after the capture edge SHALL NOT affect the in-flight result.
REQ-024 D and ZERO SHALL hold the last completed result until the next FIN; partial sums SHALL NOT appear on D.
REQ-025 DIGIT = WIDTH SHALL be legal (N=1, single RUN cycle).

Reset
REQ-026 RST_N=0 SHALL asynchronously force IDLE, counter=0, carry=0, BUSY=0, DONE=0, D=0 and ZERO=1.
REQ-027 Reset asserted mid-RUN SHALL abort the operation; no DONE pulse is produced for it.
REQ-028 After RST_N deasserts, a START on the first rising edge SHALL be accepted.

Verification
REQ-029 WIDTH=4, DIGIT=1: A=0011, B=0101, MODE=1 -> DONE pulse 5 cycles after the START edge; D=11110, ZERO=0; BUSY high for 4 cycles.
REQ-030 WIDTH=4, DIGIT=1: A=1111, B=1111, MODE=1 -> D=00000, ZERO=1. A=1111, B=0111, MODE=0 -> D=10110. A=0111, B=0011, MODE=1 -> D=00100.
REQ-031 WIDTH=8, DIGIT=2: A=0x00, B=0x01, MODE=1 -> D=1_1111_1111 after 5 cycles. A=0xFF, B=0xFF, MODE=0 -> D=1_1111_1110.
REQ-032 START held high continuously with fresh operands at each FIN -> a DONE every N+1 cycles with correct D each time; a START pulse mid-RUN changes nothing.
REQ-033 RST_N pulsed low during the 2nd RUN cycle -> D=0, ZERO=1, BUSY=0 immediately, no DONE; a subsequent operation completes correctly.
REQ-034 Randomised operands and modes for WIDTH in {4,8,16} and all legal DIGIT values -> D matches the REQ-013 model on every DONE.
